aes_sub_bytes_seq: RTL and testbench
====================================

# aes_sub_bytes_seq

Iterative forward AES SubBytes engine: accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through the FIPS-197 forward S-box. It returns the substituted state on a second valid/ready handshake. It is the encrypt-side counterpart of the inverse S-box used on the decrypt path, and sits between AddRoundKey and ShiftRows in the area-optimised encrypt datapath.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (must divide 16)
- clk  input  1  clock; all logic rising-edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  engine can accept a block
- in_data  input  128  state; byte i = in_data[127-8i -: 8] (byte 0 in MSBs, FIPS order)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  substituted state, same byte ordering
- busy  output  1  substitution in progress
- err  output  1  sticky self-check failure (see Configuration)

## Operation
- FSM states: IDLE, SUB, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load in_data into the working register, clear the byte counter, and go to SUB.
- SUB: each cycle replaces bytes cnt..cnt+LANES-1 with S(byte). cnt advances by LANES. When the final group (cnt=16-LANES) is written, go to DONE. busy=1 only in SUB.
- DONE: out_valid=1; out_data = working register, held stable. On out_valid&&out_ready, go to IDLE.
- Single buffer: in_ready=0 in SUB and DONE; no overlap of blocks.
- in_data is ignored outside the accept cycle. Upstream changes during SUB have no effect.
- Forward S-box is an internal 256-entry combinational lookup per FIPS-197 Fig. 7, replicated LANES times.
- Counter: 4 bits. Wraps to 0 on the last group, so it never exceeds 15.

## Timing
- Reset (rst_n sampled low at clk edge): state=IDLE, cnt=0, working register=0, out_valid=0, out_data=0, busy=0, err=0.
- in_ready = (state==IDLE) && rst_n; it is 0 during reset cycles and 1 from the first cycle after release.
- Latency: with accept at edge k, out_valid rises after edge k+16/LANES. LANES=4 gives 4 cycles; LANES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- Throughput: one block per 16/LANES+2 cycles with out_ready tied high. This covers accept, SUB cycles, DONE handshake, and return to IDLE.
- out_ready=1 on the first DONE cycle: out_valid is high for exactly one cycle, and in_ready is high on the next cycle.
- Backpressure: out_valid and out_data are held for any number of cycles until out_ready.
- Reset mid-SUB or mid-DONE: the block is abandoned, all outputs take their reset values at that edge, and no partial out_valid occurs.
- in_valid while not IDLE: not accepted. Upstream must hold in_valid until in_ready.

## Configuration
- AES_SBOX_SELFCHECK_EN defined:
  - Each lane's S-box output is fed through an inverse S-box lookup and compared with the original byte.
  - Any mismatch in SUB sets err, which stays high until reset.
  - err is a registered output: it rises the cycle after the faulty substitution.
- AES_SBOX_SELFCHECK_EN undefined: no inverse lookups are instantiated; err is tied 0.
- Functional behaviour of all other outputs is identical in both builds.

## Test plan
- Reset then idle: assert rst_n=0 for 2 cycles → out_valid=0, out_data=0, busy=0, err=0; in_ready=1 on the cycle after release.
- FIPS vector, LANES=4: in_data=00112233445566778899aabbccddeeff → out_data=638293c31bfc33f5c4eeacea4bc12816; out_valid rises 4 cycles after accept.
- Boundaries, LANES=1 and LANES=16: all-zero input → 636363…63; all-FF input → 161616…16; latency 16 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_data stable, in_ready=0, in_valid held high not accepted. Next block is accepted the cycle after the out handshake.
- Reset mid-SUB: assert rst_n=0 two cycles after accept (LANES=1) → next cycle out_valid=0, out_data=0, busy=0. A following block 01010101…01 yields 7c7c7c…7c.
- Round trip / self-check: 1000 random blocks with random out_ready gaps; model the expected result as the inverse S-box of out_data equalling in_data per byte. With AES_SBOX_SELFCHECK_EN defined, err stays 0 throughout.

Source files
------------

// File: rtl/aes_sub_bytes_seq.sv
// Iterative forward AES SubBytes engine: LANES bytes per cycle behind valid/ready handshakes.
// Optional build macro AES_SBOX_SELFCHECK_EN adds an inverse-S-box round-trip check driving err.
module aes_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(16 - LANES);
    localparam logic [3:0] CNT_STEP = 4'(LANES);

    // Byte 0 of the table sits in the MSBs, so SBOX[x] is S(x).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t            state;
    logic [3:0]        cnt;
    logic [0:15][7:0]  work;
    logic [0:15][7:0]  work_next;
    logic [3:0]        pos;

    assign in_ready = (state == IDLE) && rst_n;

    always_comb begin
        work_next = work;
        pos       = '0;
        for (int l = 0; l < LANES; l++) begin
            pos            = cnt + 4'(l);
            work_next[pos] = SBOX[work[pos]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SUB;
                    end
                end
                SUB: begin
                    work <= work_next;
                    cnt  <= cnt + CNT_STEP;
                    // Last group: publish the fully substituted state directly from work_next.
                    if (cnt == LAST_CNT) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= work_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_SBOX_SELFCHECK_EN
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic       mismatch;
    logic [3:0] chk_pos;
    logic       err_q;

    always_comb begin
        mismatch = 1'b0;
        chk_pos  = '0;
        for (int l = 0; l < LANES; l++) begin
            chk_pos = cnt + 4'(l);
            if (INV_SBOX[work_next[chk_pos]] != work[chk_pos]) begin
                mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state == SUB) && mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Self-checking bench for aes_sub_bytes_seq: three instances (LANES=4, 1, 16) driven from
// a directed vector table, hand-written backpressure/reset sequences and a random round trip.
module tb_aes_sub_bytes_seq;

    localparam logic [0:255][7:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];
    logic         err       [3];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: LANES=4, instance 1: LANES=1, instance 2: LANES=16.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_sub_bytes_seq #(.LANES(g == 0 ? 4 : (g == 1 ? 1 : 16))) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g]),
            .err      (err[g])
        );
    end

    typedef struct {
        int           dut;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[9];

    function automatic int lanesOf(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [127:0] data, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        in_data     = data;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept", 128'(in_ready[d]), 128'd1);
        acc = cyc + 1;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic collect(input int d, input int acc, input int gap,
                           output logic [127:0] got, output int lat);
        int n;
        n = 0;
        while (!out_valid[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("out_valid_seen", 128'(out_valid[d]), 128'd1);
        lat = cyc - acc;
        got = out_data[d];
        repeat (gap) @(negedge clk);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        checkOutput("out_valid_drop", 128'(out_valid[d]), 128'd0);
        checkOutput("in_ready_after", 128'(in_ready[d]), 128'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0]     got;
        logic [0:15][7:0] gb;
        logic [0:15][7:0] inv_blk;
        logic [127:0]     rdata;
        int               acc;
        int               lat;
        int               n;

        vecs[0] = '{0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
        vecs[1] = '{1, {16{8'h00}}, {16{8'h63}}};
        vecs[2] = '{1, {16{8'hff}}, {16{8'h16}}};
        vecs[3] = '{2, {16{8'h00}}, {16{8'h63}}};
        vecs[4] = '{2, {16{8'hff}}, {16{8'h16}}};
        vecs[5] = '{0, {16{8'h01}}, {16{8'h7c}}};
        vecs[6] = '{0, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
        vecs[7] = '{2, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
        vecs[8] = '{1, 128'h101112131415161718191a1b1c1d1e1f, 128'hca82c97dfa5947f0add4a2af9ca472c0};

        rst_n   = 1'b0;
        in_data = '0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end

        // Reset held for two edges, then released.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput("rst_out_valid", 128'(out_valid[d]), 128'd0);
            checkOutput("rst_out_data",  out_data[d],         128'd0);
            checkOutput("rst_busy",      128'(busy[d]),      128'd0);
            checkOutput("rst_err",       128'(err[d]),       128'd0);
            checkOutput("rst_in_ready",  128'(in_ready[d]),  128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput("release_in_ready", 128'(in_ready[d]), 128'd1);
        end

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].dut, vecs[i].din, acc);
            collect(vecs[i].dut, acc, 0, got, lat);
            checkOutput($sformatf("vec%0d_data", i), got, vecs[i].dout);
            checkOutput($sformatf("vec%0d_latency", i), 128'(lat), 128'(16 / lanesOf(vecs[i].dut)));
        end

        // Backpressure on LANES=4: a second block waits on in_valid while DONE is stalled.
        applyStimulus(0, 128'h00112233445566778899aabbccddeeff, acc);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_data     = 128'h000102030405060708090a0b0c0d0e0f;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_out_valid", 128'(out_valid[0]), 128'd1);
            checkOutput("bp_out_data", out_data[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
            checkOutput("bp_in_ready", 128'(in_ready[0]), 128'd0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        checkOutput("bp_drop", 128'(out_valid[0]), 128'd0);
        checkOutput("bp_next_ready", 128'(in_ready[0]), 128'd1);
        acc = cyc + 1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        checkOutput("bp_next_busy", 128'(busy[0]), 128'd1);
        collect(0, acc, 0, got, lat);
        checkOutput("bp_next_data", got, 128'h637c777bf26b6fc53001672bfed7ab76);
        checkOutput("bp_next_latency", 128'(lat), 128'd4);

        // Reset two cycles into a LANES=1 substitution abandons the block.
        applyStimulus(1, {16{8'h02}}, acc);
        @(negedge clk);
        checkOutput("midsub_busy", 128'(busy[1]), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midsub_out_valid", 128'(out_valid[1]), 128'd0);
        checkOutput("midsub_out_data",  out_data[1],         128'd0);
        checkOutput("midsub_busy_rst",  128'(busy[1]),      128'd0);
        checkOutput("midsub_in_ready",  128'(in_ready[1]),  128'd0);
        rst_n = 1'b1;
        applyStimulus(1, {16{8'h01}}, acc);
        collect(1, acc, 0, got, lat);
        checkOutput("midsub_next_data", got, {16{8'h7c}});
        checkOutput("midsub_next_latency", 128'(lat), 128'd16);

        // Random round trip: inverse S-box of each output byte must give back the input byte.
        for (int i = 0; i < 1000; i++) begin
            rdata = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(i % 3, rdata, acc);
            collect(i % 3, acc, int'($urandom_range(0, 3)), got, lat);
            gb = got;
            for (int b = 0; b < 16; b++) begin
                inv_blk[b] = INV[gb[b]];
            end
            checkOutput($sformatf("roundtrip%0d", i), inv_blk, rdata);
            checkOutput($sformatf("err%0d", i), 128'(err[i % 3]), 128'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
